sdram_frame_arbiter: RTL and testbench

Sequencer and two-port arbiter in front of the full-page SDRAM controller (512-word bursts, 15-bit {row,bank} burst address). Shares the controller between the camera write path (FIFO drained into SDRAM) and the display read path (FIFO filled from SDRAM). Generates burst addresses and manages a double-buffered frame store so the display always reads the last completed camera frame.

---
 rtl/sdram_frame_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_sdram_frame_arbiter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_frame_arbiter.sv
// Arbiter and burst sequencer that shares the full-page SDRAM controller between
// the camera write FIFO and the display read FIFO, double-buffering whole frames.
module sdram_frame_arbiter #(
   parameter int FRAME_BURSTS = 600,
   parameter int BUF1_BASE    = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_req,
   input  logic        wr_frame_start,
   input  logic        rd_req,
   input  logic        rd_frame_start,
   input  logic        ctrl_ready,
   input  logic        ctrl_f2s_valid,
   input  logic        ctrl_s2f_valid,
   output logic        ctrl_rw_en,
   output logic        ctrl_rw,
   output logic [14:0] ctrl_addr,
   output logic        wr_pop,
   output logic        rd_push,
   output logic        busy,
   output logic        wr_frame_done,
   output logic        rd_buf
);

   localparam int              IW       = $clog2(FRAME_BURSTS + 1);
   localparam logic [IW-1:0]   IDX_FULL = IW'(FRAME_BURSTS);
   localparam logic [IW-1:0]   IDX_LAST = IW'(FRAME_BURSTS - 1);
   localparam logic [IW-1:0]   IDX_ONE  = IW'(1);
   localparam logic [14:0]     BASE1    = 15'(BUF1_BASE);
   localparam logic [9:0]      BEATS    = 10'd512;
   localparam logic            GRANT_WR = 1'b0;
   localparam logic            GRANT_RD = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_ACCEPT,
      WAIT_DONE
   } state_t;

   state_t        state, state_n;
   logic          rw_en_n, rw_n, busy_n, frame_done_n, rd_buf_n;
   logic [14:0]   addr_n;
   logic          wr_buf, wr_buf_n;
   logic [IW-1:0] wr_idx, wr_idx_n, rd_idx, rd_idx_n;
   logic          done_buf, done_buf_n, done_valid, done_valid_n;
   logic          last_grant, last_grant_n;
   logic [9:0]    beat_cnt, beat_cnt_n;
   logic          wr_pend, wr_pend_n, rd_pend, rd_pend_n;
   logic          wr_start_any, rd_start_any;
   logic          wr_elig, rd_elig, beat_valid, burst_done;

   function automatic logic [14:0] burst_addr(input logic buf_sel, input logic [IW-1:0] idx);
      burst_addr = (buf_sel ? BASE1 : 15'd0) + 15'(idx);
   endfunction

   // A frame-start pulse that lands mid-burst is remembered until the burst retires.
   assign wr_start_any = wr_frame_start | wr_pend;
   assign rd_start_any = rd_frame_start | rd_pend;
   assign wr_elig      = wr_req && (wr_idx < IDX_FULL);
   assign rd_elig      = rd_req && (rd_idx < IDX_FULL);
   assign beat_valid   = ctrl_rw ? ctrl_s2f_valid : ctrl_f2s_valid;

   assign wr_pop  = ctrl_f2s_valid & busy & ~ctrl_rw;
   assign rd_push = ctrl_s2f_valid & busy &  ctrl_rw;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         ctrl_rw_en    <= 1'b0;
         ctrl_rw       <= 1'b0;
         ctrl_addr     <= 15'd0;
         busy          <= 1'b0;
         wr_frame_done <= 1'b0;
         rd_buf        <= 1'b0;
         wr_buf        <= 1'b0;
         wr_idx        <= '0;
         rd_idx        <= '0;
         done_buf      <= 1'b0;
         done_valid    <= 1'b0;
         last_grant    <= GRANT_RD;
         beat_cnt      <= 10'd0;
         wr_pend       <= 1'b0;
         rd_pend       <= 1'b0;
      end else begin
         state         <= state_n;
         ctrl_rw_en    <= rw_en_n;
         ctrl_rw       <= rw_n;
         ctrl_addr     <= addr_n;
         busy          <= busy_n;
         wr_frame_done <= frame_done_n;
         rd_buf        <= rd_buf_n;
         wr_buf        <= wr_buf_n;
         wr_idx        <= wr_idx_n;
         rd_idx        <= rd_idx_n;
         done_buf      <= done_buf_n;
         done_valid    <= done_valid_n;
         last_grant    <= last_grant_n;
         beat_cnt      <= beat_cnt_n;
         wr_pend       <= wr_pend_n;
         rd_pend       <= rd_pend_n;
      end
   end

   always_comb begin
      state_n      = state;
      rw_en_n      = 1'b0;
      rw_n         = ctrl_rw;
      addr_n       = ctrl_addr;
      busy_n       = busy;
      frame_done_n = 1'b0;
      rd_buf_n     = rd_buf;
      wr_buf_n     = wr_buf;
      wr_idx_n     = wr_idx;
      rd_idx_n     = rd_idx;
      done_buf_n   = done_buf;
      done_valid_n = done_valid;
      last_grant_n = last_grant;
      beat_cnt_n   = beat_cnt;
      wr_pend_n    = wr_start_any;
      rd_pend_n    = rd_start_any;
      burst_done   = 1'b0;

      case (state)
         IDLE: begin
            // Frame starts are applied alone so no grant is latched from a stale index.
            if (!(wr_start_any || rd_start_any)) begin
               if (wr_elig && (!rd_elig || last_grant == GRANT_RD)) begin
                  rw_n         = GRANT_WR;
                  addr_n       = burst_addr(wr_buf, wr_idx);
                  last_grant_n = GRANT_WR;
                  busy_n       = 1'b1;
                  beat_cnt_n   = 10'd0;
                  state_n      = ISSUE;
               end else if (rd_elig) begin
                  rw_n         = GRANT_RD;
                  addr_n       = burst_addr(rd_buf, rd_idx);
                  last_grant_n = GRANT_RD;
                  busy_n       = 1'b1;
                  beat_cnt_n   = 10'd0;
                  state_n      = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (ctrl_ready) begin
               rw_en_n = 1'b1;
               state_n = WAIT_ACCEPT;
            end
         end
         WAIT_ACCEPT: begin
            if (beat_valid && beat_cnt != BEATS) beat_cnt_n = beat_cnt + 10'd1;
            if (!ctrl_ready) state_n = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (beat_valid && beat_cnt != BEATS) beat_cnt_n = beat_cnt + 10'd1;
            if (beat_cnt == BEATS && ctrl_ready) begin
               burst_done = 1'b1;
               busy_n     = 1'b0;
               state_n    = IDLE;
               if (ctrl_rw) begin
                  rd_idx_n = rd_idx + IDX_ONE;
               end else begin
                  wr_idx_n = wr_idx + IDX_ONE;
                  if (wr_idx == IDX_LAST) begin
                     done_buf_n   = wr_buf;
                     done_valid_n = 1'b1;
                     frame_done_n = 1'b1;
                  end
               end
            end
         end
         default: state_n = IDLE;
      endcase

      // Uses the post-completion frame status so a finishing frame is seen by a coincident start.
      if (state == IDLE || burst_done) begin
         if (wr_start_any) begin
            wr_idx_n  = '0;
            wr_pend_n = 1'b0;
            if (done_valid_n && done_buf_n == wr_buf) wr_buf_n = ~wr_buf;
         end
         if (rd_start_any) begin
            rd_idx_n  = '0;
            rd_pend_n = 1'b0;
            if (done_valid_n) rd_buf_n = done_buf_n;
         end
      end
   end

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Self-checking bench for sdram_frame_arbiter: a behavioural controller model plus
// a burst scoreboard of expected {rw, addr} grants, using a 4-burst frame.
module tb_sdram_frame_arbiter;

   localparam int FB = 4;
   localparam int B1 = 8;

   typedef struct packed {
      logic        rw;
      logic [14:0] addr;
   } burst_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_req = 1'b0, wr_frame_start = 1'b0, rd_req = 1'b0, rd_frame_start = 1'b0;
   logic        ctrl_ready, ctrl_f2s_valid, ctrl_s2f_valid;
   logic        ctrl_rw_en, ctrl_rw, wr_pop, rd_push, busy, wr_frame_done, rd_buf;
   logic [14:0] ctrl_addr;

   int     checks = 0;
   int     failures = 0;
   int     bursts_done = 0;
   int     done_cnt = 0;
   burst_t exp_q[$];

   sdram_frame_arbiter #(.FRAME_BURSTS(FB), .BUF1_BASE(B1)) dut (
      .clk(clk), .rst(rst),
      .wr_req(wr_req), .wr_frame_start(wr_frame_start),
      .rd_req(rd_req), .rd_frame_start(rd_frame_start),
      .ctrl_ready(ctrl_ready), .ctrl_f2s_valid(ctrl_f2s_valid), .ctrl_s2f_valid(ctrl_s2f_valid),
      .ctrl_rw_en(ctrl_rw_en), .ctrl_rw(ctrl_rw), .ctrl_addr(ctrl_addr),
      .wr_pop(wr_pop), .rd_push(rd_push), .busy(busy),
      .wr_frame_done(wr_frame_done), .rd_buf(rd_buf)
   );

   always #5 clk = ~clk;

   // Controller model: accepts a request, drops ready, streams 512 beats with random gaps, then idles.
   logic       m_active, m_dir;
   logic [9:0] m_left;
   logic [1:0] m_tail;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_ready     <= 1'b1;
         ctrl_f2s_valid <= 1'b0;
         ctrl_s2f_valid <= 1'b0;
         m_active       <= 1'b0;
         m_dir          <= 1'b0;
         m_left         <= 10'd0;
         m_tail         <= 2'd0;
      end else begin
         ctrl_f2s_valid <= 1'b0;
         ctrl_s2f_valid <= 1'b0;
         if (!m_active) begin
            if (ctrl_rw_en && ctrl_ready) begin
               m_active   <= 1'b1;
               ctrl_ready <= 1'b0;
               m_dir      <= ctrl_rw;
               m_left     <= 10'd512;
               m_tail     <= 2'd3;
            end
         end else if (m_left != 10'd0) begin
            if ($urandom_range(0, 3) != 0) begin
               if (m_dir) ctrl_s2f_valid <= 1'b1;
               else       ctrl_f2s_valid <= 1'b1;
               m_left <= m_left - 10'd1;
            end
         end else if (m_tail != 2'd0) begin
            m_tail <= m_tail - 2'd1;
         end else begin
            ctrl_ready <= 1'b1;
            m_active   <= 1'b0;
         end
      end
   end

   // Scoreboard monitor: pops an expected burst per request and checks strobes and address hold at completion.
   initial begin : monitor
      burst_t cur;
      bit     prev_busy, prev_rw_en, in_burst;
      int     pops, pushes, exp_pops, exp_pushes;
      cur = '0; prev_busy = 0; prev_rw_en = 0; in_burst = 0; pops = 0; pushes = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_busy = 0; prev_rw_en = 0; in_burst = 0; pops = 0; pushes = 0;
         end else begin
            if (ctrl_rw_en) begin
               if (prev_rw_en) begin
                  checks++; failures++;
                  $display("[TB] FAIL rw_en_width: ctrl_rw_en high 2 cycles, required 1");
               end
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("[TB] FAIL grant: unexpected burst rw=%0b addr=%0d, required no burst", ctrl_rw, ctrl_addr);
                  cur = {ctrl_rw, ctrl_addr};
               end else begin
                  cur = exp_q.pop_front();
                  if ({ctrl_rw, ctrl_addr} !== {cur.rw, cur.addr}) begin
                     failures++;
                     $display("[TB] FAIL grant: got rw=%0b addr=%0d, required rw=%0b addr=%0d",
                              ctrl_rw, ctrl_addr, cur.rw, cur.addr);
                  end
               end
               in_burst = 1; pops = 0; pushes = 0;
            end
            if (wr_pop)        pops++;
            if (rd_push)       pushes++;
            if (wr_frame_done) done_cnt++;
            if (prev_busy && !busy && in_burst) begin
               exp_pops   = cur.rw ? 0 : 512;
               exp_pushes = cur.rw ? 512 : 0;
               checks++;
               if (pops != exp_pops || pushes != exp_pushes) begin
                  failures++;
                  $display("[TB] FAIL strobes: wr_pop=%0d rd_push=%0d, required %0d/%0d",
                           pops, pushes, exp_pops, exp_pushes);
               end
               checks++;
               if (ctrl_addr !== cur.addr) begin
                  failures++;
                  $display("[TB] FAIL addr_hold: addr=%0d at completion, required %0d", ctrl_addr, cur.addr);
               end
               bursts_done++;
               in_burst = 0;
            end
            prev_busy  = busy;
            prev_rw_en = ctrl_rw_en;
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push_burst(input logic rw, input int addr);
      burst_t b;
      b.rw   = rw;
      b.addr = 15'(addr);
      exp_q.push_back(b);
   endtask

   task automatic wait_bursts(input int target, output bit ok);
      int budget;
      budget = (target - bursts_done) * 1500 + 100;
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         if (bursts_done >= target) begin
            ok = 1;
            break;
         end
         tick();
      end
   endtask

   task automatic wait_in_burst(output bit ok);
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (busy && !ctrl_ready) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if ({ctrl_rw_en, ctrl_rw, busy, wr_frame_done} !== 4'b0000) begin
         failures++;
         $display("[TB] FAIL reset_ctrl: rw_en,rw,busy,done=%b, required 0000", {ctrl_rw_en, ctrl_rw, busy, wr_frame_done});
      end
      checks++;
      if (ctrl_addr !== 15'd0) begin
         failures++;
         $display("[TB] FAIL reset_addr: got %0d, required 0", ctrl_addr);
      end
      checks++;
      if ({rd_buf, wr_pop, rd_push} !== 3'b000) begin
         failures++;
         $display("[TB] FAIL reset_misc: rd_buf,wr_pop,rd_push=%b, required 000", {rd_buf, wr_pop, rd_push});
      end
      rst = 1'b0;
      repeat (2) tick();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_idle: busy=%b with no request, required 0", busy);
      end
   endtask

   task automatic test_write_frame();
      bit ok;
      int base, d0, busy_seen;
      base = bursts_done;
      d0   = done_cnt;
      for (int i = 0; i < FB; i++) push_burst(1'b0, i);
      wr_req = 1'b1;
      wait_bursts(base + FB - 1, ok);
      checks++;
      if (done_cnt != d0) begin
         failures++;
         $display("[TB] FAIL frame_done_early: pulses=%0d before last burst, required 0", done_cnt - d0);
      end
      wait_bursts(base + FB, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("[TB] FAIL write_frame_timeout: bursts=%0d, required %0d", bursts_done - base, FB);
      end
      tick();
      checks++;
      if (done_cnt - d0 != 1) begin
         failures++;
         $display("[TB] FAIL frame_done: pulses=%0d, required 1", done_cnt - d0);
      end
      busy_seen = 0;
      repeat (100) begin
         tick();
         if (busy) busy_seen++;
      end
      checks++;
      if (busy_seen != 0) begin
         failures++;
         $display("[TB] FAIL write_full_hold: busy cycles=%0d after full frame, required 0", busy_seen);
      end
   endtask

   task automatic test_reads_while_write_full();
      bit ok;
      int base;
      base = bursts_done;
      push_burst(1'b1, 0);
      rd_req = 1'b1;
      wait_bursts(base + 1, ok);
      rd_req = 1'b0;
      checks++;
      if (!ok || exp_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL read_service: done=%0d pending=%0d, required 1/0", bursts_done - base, exp_q.size());
      end
   endtask

   task automatic test_back_to_back_swap();
      bit ok;
      int base, d0;
      base = bursts_done;
      d0   = done_cnt;
      for (int i = 0; i < FB; i++) begin
         push_burst(1'b0, B1 + i);
         push_burst(1'b1, i);
      end
      wr_frame_start = 1'b1;
      rd_frame_start = 1'b1;
      wr_req = 1'b1;
      rd_req = 1'b1;
      tick();
      wr_frame_start = 1'b0;
      rd_frame_start = 1'b0;
      checks++;
      if (rd_buf !== 1'b0) begin
         failures++;
         $display("[TB] FAIL swap_rd_buf: got %b, required 0", rd_buf);
      end
      wait_bursts(base + 2 * FB, ok);
      wr_req = 1'b0;
      rd_req = 1'b0;
      checks++;
      if (!ok || exp_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL swap_bursts: done=%0d pending=%0d, required %0d/0", bursts_done - base, exp_q.size(), 2 * FB);
      end
      tick();
      checks++;
      if (done_cnt - d0 != 1) begin
         failures++;
         $display("[TB] FAIL swap_frame_done: pulses=%0d, required 1", done_cnt - d0);
      end
   endtask

   task automatic test_rd_start_mid_burst();
      bit ok;
      int base;
      base = bursts_done;
      rd_frame_start = 1'b1;
      tick();
      rd_frame_start = 1'b0;
      checks++;
      if (rd_buf !== 1'b1) begin
         failures++;
         $display("[TB] FAIL rd_buf_switch: got %b, required 1", rd_buf);
      end
      push_burst(1'b1, B1);
      push_burst(1'b1, B1);
      rd_req = 1'b1;
      wait_in_burst(ok);
      repeat (100) tick();
      rd_frame_start = 1'b1;
      tick();
      rd_frame_start = 1'b0;
      checks++;
      if (ctrl_addr !== 15'(B1)) begin
         failures++;
         $display("[TB] FAIL mid_burst_addr: got %0d, required %0d", ctrl_addr, B1);
      end
      wait_bursts(base + 2, ok);
      rd_req = 1'b0;
      checks++;
      if (!ok || exp_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL mid_burst_restart: done=%0d pending=%0d, required 2/0", bursts_done - base, exp_q.size());
      end
   endtask

   task automatic test_reset_mid_burst();
      bit ok;
      int base;
      push_burst(1'b1, B1 + 1);
      rd_req = 1'b1;
      wait_in_burst(ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("[TB] FAIL pre_reset_burst: busy=%b ready=%b, required 1/0", busy, ctrl_ready);
      end
      repeat (60) tick();
      rst    = 1'b1;
      rd_req = 1'b0;
      tick();
      checks++;
      if ({busy, ctrl_rw_en, rd_buf, rd_push, wr_pop} !== 5'b00000 || ctrl_addr !== 15'd0) begin
         failures++;
         $display("[TB] FAIL reset_mid_burst: busy,rw_en,rd_buf,rd_push,wr_pop=%b addr=%0d, required 00000/0",
                  {busy, ctrl_rw_en, rd_buf, rd_push, wr_pop}, ctrl_addr);
      end
      exp_q.delete();
      repeat (2) tick();
      rst = 1'b0;
      tick();
      base = bursts_done;
      push_burst(1'b0, 0);
      push_burst(1'b1, 0);
      push_burst(1'b0, 1);
      push_burst(1'b1, 1);
      wr_req = 1'b1;
      rd_req = 1'b1;
      tick();
      checks++;
      if ({busy, ctrl_rw_en} !== 2'b10) begin
         failures++;
         $display("[TB] FAIL grant_latency1: busy,rw_en=%b, required 10", {busy, ctrl_rw_en});
      end
      tick();
      checks++;
      if (ctrl_rw_en !== 1'b1) begin
         failures++;
         $display("[TB] FAIL grant_latency2: rw_en=%b, required 1", ctrl_rw_en);
      end
      wait_bursts(base + 1, ok);
      tick();
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL regrant_gap: busy=%b one cycle after completion, required 1", busy);
      end
      wait_bursts(base + 4, ok);
      wr_req = 1'b0;
      rd_req = 1'b0;
      checks++;
      if (!ok || exp_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL post_reset_bursts: done=%0d pending=%0d, required 4/0", bursts_done - base, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_write_frame();
      test_reads_while_write_full();
      test_back_to_back_swap();
      test_rd_start_mid_burst();
      test_reset_mid_burst();
      repeat (5) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
